// File: rtl/pc_fetch_sequencer.sv
// PC owner: fetches over imem req/ack, holds Instr until retire, then steers PC (PC+4 / PCTarget / JALR) or traps.
// Retire-to-request is one cycle (2 cycles/instr minimum); imem waits are bounded by TIMEOUT, core stalls by holding instr_ready low.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
   parameter int          TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCTarget,
   input  logic [31:0] ALUResult,
   input  logic [1:0]  PCSrc,
   input  logic        instr_ready,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic [31:0] Instr,
   output logic        instr_valid,
   output logic        trap,
   output logic        trap_cause,
   output logic [31:0] trap_pc
);

   localparam logic [0:0] S_FETCH = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   localparam int             CW      = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

   logic [0:0]    state;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   next_pc;

   assign imem_req  = (state == S_FETCH);
   assign imem_addr = PC;
   assign PCPlus4   = PC + 32'd4;

   // Reserved PCSrc encoding falls through to sequential flow.
   always_comb begin
      next_pc = PCPlus4;
      case (PCSrc)
         2'b01:   next_pc = PCTarget;
         2'b10:   next_pc = {ALUResult[31:1], 1'b0};
         default: next_pc = PCPlus4;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_FETCH;
         PC          <= RESET_VEC;
         Instr       <= 32'h0;
         instr_valid <= 1'b0;
         wait_cnt    <= '0;
         trap        <= 1'b0;
         trap_cause  <= 1'b0;
         trap_pc     <= 32'h0;
      end else begin
         trap <= 1'b0;
         case (state)
            S_FETCH: begin
               // An ack arriving on the last allowed cycle still wins over the timeout.
               if (imem_ack) begin
                  Instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  wait_cnt    <= '0;
                  state       <= S_ISSUE;
               end else if (wait_cnt == CNT_MAX) begin
                  trap       <= 1'b1;
                  trap_cause <= 1'b1;
                  trap_pc    <= PC;
                  PC         <= TRAP_VEC;
                  wait_cnt   <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= S_FETCH;
                  if (next_pc[1:0] != 2'b00) begin
                     trap       <= 1'b1;
                     trap_cause <= 1'b0;
                     trap_pc    <= next_pc;
                     PC         <= TRAP_VEC;
                  end else begin
                     PC <= next_pc;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboarded bench for pc_fetch_sequencer: expected fetch addresses and instruction words are queued as stimulus is driven.
module tb_pc_fetch_sequencer;

   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
   localparam int          TIMEOUT   = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCTarget, ALUResult, imem_rdata;
   logic [1:0]  PCSrc;
   logic        instr_ready, imem_ack;
   logic        imem_req, instr_valid, trap, trap_cause;
   logic [31:0] imem_addr, PC, PCPlus4, Instr, trap_pc;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_instr_q[$];
   logic [31:0] mpc;

   pc_fetch_sequencer #(
      .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .PCTarget(PCTarget), .ALUResult(ALUResult),
      .PCSrc(PCSrc), .instr_ready(instr_ready), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
      .PC(PC), .PCPlus4(PCPlus4), .Instr(Instr), .instr_valid(instr_valid),
      .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pop_addr(output logic [31:0] v);
      if (exp_addr_q.size() == 0) begin
         check_eq("addr_q_empty", 32'd0, 32'd1);
         v = 32'hxxxx_xxxx;
      end else v = exp_addr_q.pop_front();
   endtask

   // Waits for a request, checks the address, holds ack low for 'waits' cycles, then acks.
   task automatic fetch(input logic [31:0] rdata, input int waits);
      int guard = 0;
      logic [31:0] ea, ei;
      while (!imem_req && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_eq("req_seen", {31'd0, imem_req}, 32'd1);
      pop_addr(ea);
      check_eq("imem_addr", imem_addr, ea);
      check_eq("pc", PC, ea);
      check_eq("pc_plus4", PCPlus4, ea + 32'd4);
      for (int i = 0; i < waits; i++) begin
         instr_ready = 1'b1;   // ignored while fetching
         @(negedge clk);
      end
      instr_ready = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = rdata;
      exp_instr_q.push_back(rdata);
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      ei = exp_instr_q.pop_front();
      check_eq("instr_valid", {31'd0, instr_valid}, 32'd1);
      check_eq("instr", Instr, ei);
      check_eq("req_in_issue", {31'd0, imem_req}, 32'd0);
      check_eq("no_trap_fetch", {31'd0, trap}, 32'd0);
   endtask

   task automatic retire(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
      logic [31:0] nx;
      logic        bad;
      case (src)
         2'b01:   nx = tgt;
         2'b10:   nx = alu & 32'hFFFF_FFFE;
         default: nx = mpc + 32'd4;
      endcase
      bad = (nx[1:0] != 2'b00);
      mpc = bad ? TRAP_VEC : nx;
      exp_addr_q.push_back(mpc);
      PCSrc = src; PCTarget = tgt; ALUResult = alu;
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      PCSrc = $urandom; PCTarget = $urandom; ALUResult = $urandom;
      check_eq("valid_cleared", {31'd0, instr_valid}, 32'd0);
      check_eq("req_after_ready", {31'd0, imem_req}, 32'd1);
      check_eq("trap_retire", {31'd0, trap}, {31'd0, bad});
      if (bad) begin
         check_eq("cause_misalign", {31'd0, trap_cause}, 32'd0);
         check_eq("trap_pc_misalign", trap_pc, nx);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ea;
      reset = 1'b0; PCTarget = 0; ALUResult = 0; PCSrc = 0;
      instr_ready = 0; imem_ack = 0; imem_rdata = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_pc", PC, RESET_VEC);
      check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("rst_instr", Instr, 32'd0);
      check_eq("rst_trap", {31'd0, trap}, 32'd0);
      check_eq("rst_trap_pc", trap_pc, 32'd0);
      reset = 1'b1;
      mpc = RESET_VEC;
      exp_addr_q.push_back(mpc);

      fetch(32'h0050_0093, 0);
      retire(2'b00, 32'h0, 32'h0);                  // -> 4
      fetch(32'h1111_0013, 1);
      retire(2'b00, 32'h0, 32'h0);                  // -> 8
      fetch(32'h2222_0013, 0);
      retire(2'b01, 32'h40, 32'h0);                 // branch -> 0x40
      fetch(32'h3333_0013, 2);
      retire(2'b10, 32'h0, 32'h81);                 // JALR -> 0x80
      fetch(32'h4444_0013, 0);
      retire(2'b01, 32'h42, 32'h0);                 // misaligned -> trap, 0x100
      fetch(32'h5555_0013, TIMEOUT - 1);            // ack on last allowed cycle
      retire(2'b01, 32'h10, 32'h0);                 // -> 0x10

      // Fetch timeout at 0x10.
      begin
         int guard = 0;
         while (!imem_req && guard < 50) begin @(negedge clk); guard++; end
         pop_addr(ea);
         check_eq("to_addr", imem_addr, ea);
         repeat (TIMEOUT - 1) @(negedge clk);
         check_eq("to_no_early_trap", {31'd0, trap}, 32'd0);
         @(negedge clk);
         check_eq("to_trap", {31'd0, trap}, 32'd1);
         check_eq("to_cause", {31'd0, trap_cause}, 32'd1);
         check_eq("to_trap_pc", trap_pc, ea);
         check_eq("to_redirect", imem_addr, TRAP_VEC);
         mpc = TRAP_VEC;
         exp_addr_q.push_back(mpc);
         @(negedge clk);
         check_eq("trap_pulse_end", {31'd0, trap}, 32'd0);
      end

      fetch(32'h6666_0013, 0);
      retire(2'b01, 32'hFFFF_FFFC, 32'h0);
      fetch(32'h7777_0013, 0);
      check_eq("wrap_plus4", PCPlus4, 32'h0);
      retire(2'b00, 32'h0, 32'h0);                  // wraps to 0, no trap
      fetch(32'h8888_0013, 2);
      retire(2'b11, 32'h40, 32'h80);                // reserved -> PC+4
      fetch(32'h9999_0013, 0);

      // Stray ack during ISSUE must not disturb Instr.
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
      check_eq("stray_ack_instr", Instr, 32'h9999_0013);
      check_eq("stray_ack_valid", {31'd0, instr_valid}, 32'd1);

      // Asynchronous reset while issuing.
      reset = 1'b0;
      #1;
      check_eq("arst_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("arst_pc", PC, RESET_VEC);
      check_eq("arst_trap", {31'd0, trap}, 32'd0);
      @(negedge clk);
      check_eq("arst_hold_trap", {31'd0, trap}, 32'd0);
      reset = 1'b1;
      exp_addr_q.delete();
      mpc = RESET_VEC;
      exp_addr_q.push_back(mpc);
      fetch(32'hAAAA_0013, 0);
      retire(2'b00, 32'h0, 32'h0);
      fetch(32'hBBBB_0013, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
